// File: rtl/multiword_add_pkg.sv
// Shared definitions for the multi-word sequential adder.
//   state_e  : controller states (idle / run / done)
//   SLICE_W  : width of the shared adder slice
//   slice_lo : bit offset of a word slice within a wide operand
package multiword_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Lowest bit of word slice idx within a SLICE_W-granular vector.
  function automatic int unsigned slice_lo(input int unsigned idx);
    return idx * SLICE_W;
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Operand/result handshake bundle for multiword_add_seq.
//   master : operand producer / result consumer side
//   slave  : adder side
// Signals: in_valid/in_ready (operand handshake), A, B, Cin (operands),
// out_valid/out_ready (result handshake), Sum, Carry, Ovf (result), busy.
// Optional MULTIWORD_ADD_SUB_EN adds the 'sub' operation select.
interface multiword_add_seq_if #(
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = multiword_add_pkg::SLICE_W * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
`ifdef MULTIWORD_ADD_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Carry;
  logic         Ovf;
  logic         busy;

  modport master (
`ifdef MULTIWORD_ADD_SUB_EN
    output sub,
`endif
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, Sum, Carry, Ovf, busy
  );

  modport slave (
`ifdef MULTIWORD_ADD_SUB_EN
    input  sub,
`endif
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, Sum, Carry, Ovf, busy
  );

endinterface

// File: rtl/add16_slice.sv
// Combinational 16-bit adder slice shared by all words of a wide add.
//   a, b     : slice operands
//   cin      : carry into bit 0
//   s        : slice sum
//   cout     : carry out of bit 15
//   c_msb_in : carry into bit 15 (signed overflow = c_msb_in ^ cout)
module add16_slice
  import multiword_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  logic [SLICE_W:0] total;

  always_comb begin
    total    = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
    s        = total[SLICE_W-1:0];
    cout     = total[SLICE_W];
    // Sum MSB = a ^ b ^ carry-in, so the carry-in is recoverable from the sum.
    c_msb_in = a[SLICE_W-1] ^ b[SLICE_W-1] ^ total[SLICE_W-1];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision adder: one WORDS x 16-bit add done over WORDS cycles on a
// single 16-bit slice, least significant word first, with a registered carry
// between words.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of multiword_add_seq_if (operand and result
//              valid/ready handshakes, Sum/Carry/Ovf result, busy)
// Parameters: WORDS (2..8) slices per operand, CNT_W word-index width with
// 2**CNT_W >= WORDS.
// Optional feature: define MULTIWORD_ADD_SUB_EN to add bus.sub, selecting
// A - B (computed as A + ~B + 1, Cin ignored).
module multiword_add_seq
  import multiword_add_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic                clk,
  input logic                rst,
  multiword_add_seq_if.slave bus
);

  localparam int unsigned W = SLICE_W * WORDS;
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WORDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef MULTIWORD_ADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic               accept;
  logic               last_word;
  logic [SLICE_W-1:0] a_word, b_word, s_word;
  logic               s_cout, s_cmsb;

  assign accept    = (state_q == StIdle) && bus.in_valid;
  assign last_word = (idx_q == LastIdx);

  // Word mux feeding the shared slice.
  always_comb begin
    a_word = a_q[slice_lo(32'(idx_q)) +: SLICE_W];
    b_word = b_q[slice_lo(32'(idx_q)) +: SLICE_W];
`ifdef MULTIWORD_ADD_SUB_EN
    if (sub_q) begin
      b_word = ~b_word;
    end
`endif
  end

  add16_slice u_slice (
    .a        (a_word),
    .b        (b_word),
    .cin      (carry_q),
    .s        (s_word),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.in_valid) state_d = StRun;
      StRun:  if (last_word)    state_d = StDone;
      StDone: if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef MULTIWORD_ADD_SUB_EN
    sub_d   = sub_q;
`endif
    if (accept) begin
      a_d     = bus.A;
      b_d     = bus.B;
      sum_d   = '0;
      idx_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      carry_d = bus.Cin;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_d   = bus.sub;
      // Two's complement subtract: the +1 enters as the initial carry.
      if (bus.sub) begin
        carry_d = 1'b1;
      end
`endif
    end else if (state_q == StRun) begin
      sum_d[slice_lo(32'(idx_q)) +: SLICE_W] = s_word;
      carry_d = s_cout;
      if (last_word) begin
        idx_d  = '0;
        cout_d = s_cout;
        ovf_d  = s_cmsb ^ s_cout;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Outputs.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.busy      = (state_q == StRun);
    bus.out_valid = (state_q == StDone);
    bus.Sum       = sum_q;
    bus.Carry     = cout_q;
    bus.Ovf       = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq with WORDS=4 (64-bit operands).
module tb_multiword_add_seq;

  localparam int unsigned WORDS = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiword_add_seq_if #(.WORDS(WORDS)) bus ();

  multiword_add_seq #(
    .WORDS (WORDS),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands in a cycle where in_ready is high (handshake cycle = 0),
  // scramble the inputs afterwards, and return how many negedge samples later
  // out_valid is seen (bounded).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                        input logic s, output int lat);
    bus.A = a;
    bus.B = b;
    bus.Cin = cin;
`ifdef MULTIWORD_ADD_SUB_EN
    bus.sub = s;
`endif
    bus.in_valid = 1'b1;
    chk("in_ready_at_accept", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    bus.Cin = ~cin;
`ifdef MULTIWORD_ADD_SUB_EN
    bus.sub = ~s;
`endif
    lat = 1;
    chk("busy_in_run", {63'd0, bus.busy}, 64'd1);
    chk("in_ready_in_run", {63'd0, bus.in_ready}, 64'd0);
    chk("sum_cleared_in_run", bus.Sum, 64'd0);
    while (!bus.out_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("out_valid_drops", {63'd0, bus.out_valid}, 64'd0);
    chk("in_ready_after_done", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_sum", bus.Sum, 64'd0);
    chk("rst_carry", {63'd0, bus.Carry}, 64'd0);
    chk("rst_ovf", {63'd0, bus.Ovf}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All-ones + 1: carry ripples through every word boundary.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_sum", bus.Sum, 64'h0);
    chk("t1_carry", {63'd0, bus.Carry}, 64'd1);
    chk("t1_ovf", {63'd0, bus.Ovf}, 64'd0);
    finish_op();

    // Largest positive + 1: signed overflow, no carry.
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat);
    chk("t2_latency", 64'(lat), 64'd5);
    chk("t2_sum", bus.Sum, 64'h8000_0000_0000_0000);
    chk("t2_carry", {63'd0, bus.Carry}, 64'd0);
    chk("t2_ovf", {63'd0, bus.Ovf}, 64'd1);
    finish_op();

    // Per-word sums with carry-in.
    run_op(64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 1'b1, 1'b0, lat);
    chk("t3_latency", 64'(lat), 64'd5);
    chk("t3_sum", bus.Sum, 64'h0005_0005_0005_0006);
    chk("t3_carry", {63'd0, bus.Carry}, 64'd0);
    chk("t3_ovf", {63'd0, bus.Ovf}, 64'd0);
    finish_op();

    // Backpressure: result held while new operands wait.
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, lat);
    chk("t4_latency", 64'(lat), 64'd5);
    bus.A = 64'h1234;
    bus.B = 64'h1111;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("t4_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("t4_hold_sum", bus.Sum, 64'h0);
      chk("t4_hold_carry", {63'd0, bus.Carry}, 64'd1);
      chk("t4_hold_ovf", {63'd0, bus.Ovf}, 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("t4_out_valid_drops", {63'd0, bus.out_valid}, 64'd0);
    run_op(64'h1234, 64'h1111, 1'b0, 1'b0, lat);
    chk("t4_new_latency", 64'(lat), 64'd5);
    chk("t4_new_sum", bus.Sum, 64'h2345);
    chk("t4_new_carry", {63'd0, bus.Carry}, 64'd0);
    finish_op();

    // Reset in the second RUN cycle aborts the operation.
    bus.A = 64'h7;
    bus.B = 64'h9;
    bus.Cin = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("t5_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("t5_busy", {63'd0, bus.busy}, 64'd0);
    chk("t5_sum", bus.Sum, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    chk("t5_no_out_valid", {63'd0, seen}, 64'd0);
    run_op(64'd2, 64'd3, 1'b0, 1'b0, lat);
    chk("t5_latency", 64'(lat), 64'd5);
    chk("t5_add_sum", bus.Sum, 64'd5);
    finish_op();

`ifdef MULTIWORD_ADD_SUB_EN
    // Subtract: Cin driven high to show it is ignored.
    run_op(64'd0, 64'd1, 1'b1, 1'b1, lat);
    chk("t6_latency", 64'(lat), 64'd5);
    chk("t6_sum", bus.Sum, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_carry", {63'd0, bus.Carry}, 64'd0);
    chk("t6_ovf", {63'd0, bus.Ovf}, 64'd0);
    finish_op();
    run_op(64'd5, 64'd3, 1'b1, 1'b1, lat);
    chk("t7_sum", bus.Sum, 64'd2);
    chk("t7_carry", {63'd0, bus.Carry}, 64'd1);
    chk("t7_ovf", {63'd0, bus.Ovf}, 64'd0);
    finish_op();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
